// File: rtl/bounce_pkg.sv
// Shared types and constants for the bounce step sequencer.
package bounce_pkg;

    localparam logic [3:0]  VMAX      = 4'd15;
    localparam int unsigned CMD_LEN_W = 4;

    typedef logic [1:0] step_t;

    typedef struct packed {
        step_t                step;
        logic [CMD_LEN_W-1:0] len;
    } cmd_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/bounce_step_sequencer_core.sv
// Bouncing 4-bit up/down counter: value, direction and end-point dwell.
module bounce_core
    import bounce_pkg::*;
(
    input  logic       clk,
    input  logic       clear_i,
    input  logic       step_en_i,
    input  logic [1:0] step_i,
    output logic [3:0] value_o,
    output logic       dir_down_o,
    output logic       bounce_o,
    output logic       bounce_c
);

    logic [3:0] value_q, value_d;
    logic       dir_down_q, dir_down_d;
    logic       dwell_q, dwell_d;
    logic       bounce_q;
    logic [4:0] sum_c, diff_c;

    // Step rule; 5-bit arithmetic exposes overshoot past either end.
    always_comb begin
        value_d    = value_q;
        dir_down_d = dir_down_q;
        dwell_d    = dwell_q;
        bounce_c   = 1'b0;
        sum_c      = {1'b0, value_q} + {3'b000, step_i};
        diff_c     = {1'b0, value_q} - {3'b000, step_i};
        if (step_en_i && (step_i != 2'd0)) begin
            if (dwell_q) begin
                // Direction already flipped at the end point; this step only pays the dwell.
                dwell_d = 1'b0;
            end else if (!dir_down_q) begin
                if (sum_c < {1'b0, VMAX}) begin
                    value_d = sum_c[3:0];
                end else begin
                    value_d    = VMAX;
                    dir_down_d = 1'b1;
                    dwell_d    = (sum_c == {1'b0, VMAX});
                    bounce_c   = 1'b1;
                end
            end else begin
                if (diff_c[4]) begin
                    value_d    = 4'd0;
                    dir_down_d = 1'b0;
                    bounce_c   = 1'b1;
                end else if (diff_c == 5'd0) begin
                    value_d    = 4'd0;
                    dir_down_d = 1'b0;
                    dwell_d    = 1'b1;
                    bounce_c   = 1'b1;
                end else begin
                    value_d = diff_c[3:0];
                end
            end
        end
    end

    // Counter registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clear_i) begin
            value_q    <= 4'd0;
            dir_down_q <= 1'b0;
            dwell_q    <= 1'b0;
            bounce_q   <= 1'b0;
        end else begin
            value_q    <= value_d;
            dir_down_q <= dir_down_d;
            dwell_q    <= dwell_d;
            bounce_q   <= bounce_c;
        end
    end

    assign value_o    = value_q;
    assign dir_down_o = dir_down_q;
    assign bounce_o   = bounce_q;

endmodule

// File: rtl/bounce_step_sequencer.sv
// Command FIFO plus IDLE/RUN sequencer that drives the bouncing counter core.
module bounce_step_sequencer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned LEN_W  = 4,
    parameter int unsigned BCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_step,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              pause,
    input  logic              flush,
    output logic [3:0]        value,
    output logic              dir_down,
    output logic              bounce,
    output logic [BCNT_W-1:0] bounce_cnt,
    output logic              busy,
    output logic              done
);
    import bounce_pkg::*;

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        step_t            step;
        logic [LEN_W-1:0] len;
    } ent_t;

    ent_t              fifo_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              empty_c, full_c, push_c, pop_c;
    ent_t              head_c;

    state_t            state_q, state_d;
    step_t             cur_step_q, cur_step_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              done_q, done_d;
    logic              step_en_c;
    logic              bounce_c;
    logic [BCNT_W-1:0] bounce_cnt_q;

    assign empty_c   = (count_q == '0);
    assign full_c    = (count_q == CNT_W'(DEPTH));
    assign cmd_ready = !full_c && !flush && !rst;
    assign push_c    = cmd_valid && cmd_ready;
    assign head_c    = fifo_q[rd_ptr_q];

    // Next state: pop on IDLE exit and on retire (back-to-back), freeze on pause.
    always_comb begin
        state_d    = state_q;
        cur_step_d = cur_step_q;
        rem_d      = rem_q;
        done_d     = 1'b0;
        pop_c      = 1'b0;
        step_en_c  = 1'b0;
        if (!flush) begin
            unique case (state_q)
                IDLE: begin
                    if (!empty_c) begin
                        pop_c      = 1'b1;
                        cur_step_d = head_c.step;
                        rem_d      = head_c.len;
                        state_d    = RUN;
                    end
                end
                RUN: begin
                    if (!pause) begin
                        if (rem_q > LEN_W'(1)) begin
                            step_en_c = 1'b1;
                            rem_d     = rem_q - LEN_W'(1);
                        end else begin
                            // rem of 1 takes its last step; rem of 0 retires with no step.
                            step_en_c = (rem_q == LEN_W'(1));
                            done_d    = 1'b1;
                            if (!empty_c) begin
                                pop_c      = 1'b1;
                                cur_step_d = head_c.step;
                                rem_d      = head_c.len;
                            end else begin
                                state_d = IDLE;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end else begin
            state_d = IDLE;
        end
    end

    // Sequencer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cur_step_q   <= 2'd0;
            rem_q        <= '0;
            done_q       <= 1'b0;
            bounce_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cur_step_q <= cur_step_d;
            rem_q      <= rem_d;
            done_q     <= done_d;
            if (bounce_c && (bounce_cnt_q != '1)) begin
                bounce_cnt_q <= bounce_cnt_q + BCNT_W'(1);
            end
        end
    end

    // FIFO pointers and occupancy; flush empties it.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push_c && !pop_c) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!push_c && pop_c) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_q[wr_ptr_q] <= '{step: cmd_step, len: cmd_len};
        end
    end

    bounce_core u_core (
        .clk        (clk),
        .clear_i    (rst),
        .step_en_i  (step_en_c),
        .step_i     (cur_step_q),
        .value_o    (value),
        .dir_down_o (dir_down),
        .bounce_o   (bounce),
        .bounce_c   (bounce_c)
    );

    assign bounce_cnt = bounce_cnt_q;
    assign busy       = (state_q == RUN);
    assign done       = done_q;

endmodule

// File: tb/tb_bounce_step_sequencer.sv
// Randomized and directed bench for bounce_step_sequencer with a queue-based reference model.
module tb_bounce_step_sequencer;
    import bounce_pkg::*;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned LEN_W  = CMD_LEN_W;
    localparam int unsigned BCNT_W = 8;
    localparam int          BMAX   = (1 << BCNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_step = 2'd0;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic              pause = 1'b0;
    logic              flush = 1'b0;
    logic [3:0]        value;
    logic              dir_down;
    logic              bounce;
    logic [BCNT_W-1:0] bounce_cnt;
    logic              busy;
    logic              done;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bounce_step_sequencer #(.DEPTH(DEPTH), .LEN_W(LEN_W), .BCNT_W(BCNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_step   (cmd_step),
        .cmd_len    (cmd_len),
        .pause      (pause),
        .flush      (flush),
        .value      (value),
        .dir_down   (dir_down),
        .bounce     (bounce),
        .bounce_cnt (bounce_cnt),
        .busy       (busy),
        .done       (done)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: command queue, running command and counter position.
    cmd_t mq[$];
    int   m_run, m_step, m_rem;
    int   m_val, m_down, m_dwell, m_bcnt;
    int   m_bounce, m_done;

    task automatic m_load();
        cmd_t c;
        c      = mq.pop_front();
        m_step = int'(c.step);
        m_rem  = int'(c.len);
        m_run  = 1;
    endtask

    task automatic m_retire();
        m_done = 1;
        if (mq.size() > 0) m_load();
        else m_run = 0;
    endtask

    task automatic m_apply(input int s);
        int t;
        if (s != 0) begin
            if (m_dwell != 0) begin
                m_dwell = 0;
            end else if (m_down == 0) begin
                t = m_val + s;
                if (t >= 15) begin
                    m_val = 15; m_down = 1; m_dwell = (t == 15); m_bounce = 1;
                end else begin
                    m_val = t;
                end
            end else begin
                t = m_val - s;
                if (t <= 0) begin
                    m_val = 0; m_down = 0; m_dwell = (t == 0); m_bounce = 1;
                end else begin
                    m_val = t;
                end
            end
            if (m_bounce != 0 && m_bcnt < BMAX) m_bcnt++;
        end
    endtask

    task automatic model_edge(input bit r, input bit psh, input int s, input int l,
                              input bit p, input bit f);
        cmd_t c;
        m_done   = 0;
        m_bounce = 0;
        if (r) begin
            mq.delete();
            m_run = 0; m_rem = 0; m_step = 0;
            m_val = 0; m_down = 0; m_dwell = 0; m_bcnt = 0;
        end else if (f) begin
            mq.delete();
            m_run = 0;
        end else begin
            if (m_run == 0) begin
                if (mq.size() > 0) m_load();
            end else if (!p) begin
                if (m_rem == 0) begin
                    m_retire();
                end else begin
                    m_apply(m_step);
                    m_rem--;
                    if (m_rem == 0) m_retire();
                end
            end
            if (psh) begin
                c.step = step_t'(s);
                c.len  = CMD_LEN_W'(l);
                mq.push_back(c);
            end
        end
    endtask

    // One clock: drive inputs, check ready mid-cycle, advance model, check outputs after the edge.
    task automatic cyc(input bit r, input bit v, input int s, input int l, input bit p, input bit f);
        bit exp_ready;
        rst       = r;
        cmd_valid = v;
        cmd_step  = 2'(s);
        cmd_len   = LEN_W'(l);
        pause     = p;
        flush     = f;
        @(negedge clk);
        exp_ready = !r && !f && (mq.size() < DEPTH);
        check_eq("cmd_ready", int'(cmd_ready), int'(exp_ready));
        @(posedge clk);
        model_edge(r, v && exp_ready, s, l, p, f);
        #1;
        check_eq("value", int'(value), m_val);
        check_eq("dir_down", int'(dir_down), m_down);
        check_eq("bounce", int'(bounce), m_bounce);
        check_eq("bounce_cnt", int'(bounce_cnt), m_bcnt);
        check_eq("busy", int'(busy), m_run);
        check_eq("done", int'(done), m_done);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic push(input int s, input int l);
        cyc(1'b0, 1'b1, s, l, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        bit r, v, p, f;
        int s, l;

        // Up-count to a dwell at 15, then down.
        do_reset();
        check_eq("rst_value", int'(value), 0);
        check_eq("rst_busy", int'(busy), 0);
        push(3, 6);
        idle(8);
        check_eq("t1_top", int'(value), 15);
        check_eq("t1_dir", int'(dir_down), 1);
        push(2, 3);
        idle(5);
        check_eq("t1_val", int'(value), 9);

        // From 9 going down: dwell at 0, then up.
        push(3, 4);
        idle(6);
        check_eq("t3_zero", int'(value), 0);
        check_eq("t3_dir", int'(dir_down), 0);
        push(1, 1);
        idle(3);
        check_eq("t3_val", int'(value), 1);
        check_eq("t3_bcnt", int'(bounce_cnt), 2);

        // Overshoot clamps at 15 with no dwell.
        do_reset();
        push(2, 8);
        idle(10);
        check_eq("t2_top", int'(value), 15);
        push(1, 1);
        idle(3);
        check_eq("t2_val", int'(value), 14);
        check_eq("t2_bcnt", int'(bounce_cnt), 1);

        // Fill while paused, then flush.
        do_reset();
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1, 2, 1'b1, 1'b0);
        check_eq("t4_full", int'(cmd_ready), 0);
        cyc(1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
        check_eq("t4_busy", int'(busy), 0);
        check_eq("t4_val", int'(value), 0);
        idle(3);

        // Zero-length command back-to-back, then a paused command.
        do_reset();
        push(1, 0);
        push(1, 2);
        idle(6);
        check_eq("t5_val", int'(value), 2);
        push(1, 5);
        idle(2);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
        idle(6);
        check_eq("t5_end", int'(value), 7);

        // Reset in the middle of a command.
        do_reset();
        push(1, 10);
        idle(8);
        check_eq("t6_mid", int'(value), 7);
        cyc(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        check_eq("t6_val", int'(value), 0);
        check_eq("t6_busy", int'(busy), 0);
        idle(3);
        check_eq("t6_idle", int'(busy), 0);

        // Random traffic.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            r = ($urandom_range(0, 199) == 0);
            v = ($urandom_range(0, 1) == 1);
            s = int'($urandom_range(0, 3));
            l = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 4));
            p = ($urandom_range(0, 4) == 0);
            f = ($urandom_range(0, 39) == 0);
            cyc(r, v, s, l, p, f);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
